// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for a 4-digit BCD display.
// Each digit gets one slot of REFRESH_DIV cycles. The first GUARD cycles of a
// slot are blanked to hide ghosting while the digit enables switch over.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   enable      scan enable; dropping it abandons the current slot
//   digits_in   four BCD digits, digit i at [4*i+3:4*i]
//   blink_mask  per-digit blink enable, captured at each frame start
//   blink_tick  single-cycle pulse that toggles the blink phase
//   lz_blank    blank digit3 when it is zero (applied live)
//   digit_sel   active digit index
//   digit_val   BCD value for the decoder, 4'hF = blank
//   frame_start one-cycle pulse in the first cycle of each digit-0 slot
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] digits_in,
  input  logic [3:0]  blink_mask,
  input  logic        blink_tick,
  input  logic        lz_blank,
  output logic [1:0]  digit_sel,
  output logic [3:0]  digit_val,
  output logic        frame_start
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD_LAST = CNT_W'(GUARD - 1);
  localparam logic [3:0]       BLANK          = 4'hF;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sel;
  logic [15:0]      snap;
  logic [3:0]       snap_mask;
  logic             blink_phase;

  logic [3:0]       cur_digit;

  // Scan sequencer: slot counter, digit index and frame snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_OFF;
      cnt         <= '0;
      sel         <= '0;
      snap        <= 16'hFFFF;
      snap_mask   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (blink_tick) begin
        blink_phase <= ~blink_phase;
      end

      case (state)
        ST_OFF: begin
          cnt <= '0;
          sel <= '0;
          if (enable) begin
            state     <= ST_GUARD;
            snap      <= digits_in;
            snap_mask <= blink_mask;
          end
        end

        ST_GUARD, ST_SHOW: begin
          if (!enable) begin
            // Abandon the slot; takes precedence over a wrap in the same cycle.
            state <= ST_OFF;
            cnt   <= '0;
            sel   <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            sel   <= sel + 2'd1;
            state <= ST_GUARD;
            // Snapshot only when wrapping into digit 0 so a frame never tears.
            if (sel == 2'd3) begin
              snap      <= digits_in;
              snap_mask <= blink_mask;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_GUARD_LAST) begin
              state <= ST_SHOW;
            end
          end
        end

        default: begin
          state <= ST_OFF;
          cnt   <= '0;
          sel   <= '0;
        end
      endcase
    end
  end

  assign digit_sel   = sel;
  assign frame_start = (state != ST_OFF) && (sel == 2'd0) && (cnt == '0);

  // Digit value with blink, leading-zero and illegal-code blanking.
  always_comb begin
    cur_digit = snap[{sel, 2'b00} +: 4];
    digit_val = BLANK;
    if (state == ST_SHOW) begin
      if ((blink_phase && snap_mask[sel]) ||
          (lz_blank && (sel == 2'd3) && (cur_digit == 4'd0)) ||
          (cur_digit > 4'd9)) begin
        digit_val = BLANK;
      end else begin
        digit_val = cur_digit;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with REFRESH_DIV=8, GUARD=2 (32-cycle frame).
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  blink_mask;
  logic        blink_tick;
  logic        lz_blank;
  logic [1:0]  digit_sel;
  logic [3:0]  digit_val;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  display_scan_ctrl #(
    .REFRESH_DIV(8),
    .GUARD(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .digits_in  (digits_in),
    .blink_mask (blink_mask),
    .blink_tick (blink_tick),
    .lz_blank   (lz_blank),
    .digit_sel  (digit_sel),
    .digit_val  (digit_val),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks one 32-cycle frame starting at sel=0,cnt=0. exp holds the digit
  // shown in each slot (4'hF where blanking is expected). Inputs may be
  // changed after the check at cycle mid_k; tick_end pulses blink_tick on
  // the frame's last edge.
  task automatic run_frame(input string name, input logic [15:0] exp,
                           input int mid_k, input logic [15:0] mid_digits,
                           input logic [3:0] mid_mask, input logic mid_lz,
                           input logic tick_end);
    for (int k = 0; k < 32; k++) begin
      logic [1:0] es;
      logic [3:0] ev;
      logic       ef;
      es = 2'(k / 8);
      ev = ((k % 8) < 2) ? 4'hF : exp[(k / 8) * 4 +: 4];
      ef = (k == 0);
      n_checks++;
      if ({digit_sel, digit_val, frame_start} !== {es, ev, ef}) begin
        n_fail++;
        $display("FAIL %s k=%0d: got sel=%0d val=%h fs=%b, expected sel=%0d val=%h fs=%b",
                 name, k, digit_sel, digit_val, frame_start, es, ev, ef);
      end
      if (k == mid_k) begin
        digits_in  = mid_digits;
        blink_mask = mid_mask;
        lz_blank   = mid_lz;
      end
      if (k == 31 && tick_end) blink_tick = 1'b1;
      step();
      blink_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    enable     = 1'b1;
    blink_tick = 1'b1;
    digits_in  = 16'h1234;
    blink_mask = 4'b0000;
    lz_blank   = 1'b0;
    step();
    step();
    blink_tick = 1'b0;
    n_checks++;
    if ({digit_sel, digit_val, frame_start} !== {2'd0, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: got sel=%0d val=%h fs=%b, expected sel=0 val=f fs=0",
               digit_sel, digit_val, frame_start);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({digit_sel, digit_val, frame_start} !== {2'd0, 4'hF, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_release: got sel=%0d val=%h fs=%b, expected sel=0 val=f fs=1",
               digit_sel, digit_val, frame_start);
    end
  endtask

  task automatic test_basic_scan();
    run_frame("basic", 16'h1234, -1, 16'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_snapshot();
    run_frame("snap_mid", 16'h1234, 10, 16'h5678, 4'b0000, 1'b0, 1'b0);
    run_frame("snap_next", 16'h5678, 3, 16'h1234, 4'b0011, 1'b0, 1'b1);
  endtask

  task automatic test_blink_lz_illegal();
    run_frame("blink_on", 16'h12FF, 3, 16'h0945, 4'b0011, 1'b1, 1'b1);
    run_frame("blink_off_lz", 16'hF945, 31, 16'h0945, 4'b0011, 1'b0, 1'b0);
    run_frame("lz_off", 16'h0945, 31, 16'h00A0, 4'b0000, 1'b0, 1'b0);
    run_frame("illegal", 16'h00F0, -1, 16'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 21; i++) step();
    n_checks++;
    if ({digit_sel, digit_val, frame_start} !== {2'd2, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL drop_pre: got sel=%0d val=%h fs=%b, expected sel=2 val=0 fs=0",
               digit_sel, digit_val, frame_start);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({digit_sel, digit_val, frame_start} !== {2'd0, 4'hF, 1'b0}) begin
        n_fail++;
        $display("FAIL drop_off[%0d]: got sel=%0d val=%h fs=%b, expected sel=0 val=f fs=0",
                 i, digit_sel, digit_val, frame_start);
      end
    end
    digits_in = 16'h1234;
    enable    = 1'b1;
    step();
    run_frame("restart", 16'h1234, -1, 16'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_and_wrap_drop();
    for (int i = 0; i < 26; i++) step();
    n_checks++;
    if ({digit_sel, digit_val} !== {2'd3, 4'h1}) begin
      n_fail++;
      $display("FAIL rmid_pre: got sel=%0d val=%h, expected sel=3 val=1", digit_sel, digit_val);
    end
    blink_tick = 1'b1;
    step();
    blink_tick = 1'b0;
    rst = 1'b1;
    step();
    n_checks++;
    if ({digit_sel, digit_val, frame_start} !== {2'd0, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL rmid: got sel=%0d val=%h fs=%b, expected sel=0 val=f fs=0",
               digit_sel, digit_val, frame_start);
    end
    // Blink phase must have been cleared by reset, so a full mask shows digits.
    blink_mask = 4'b1111;
    rst = 1'b0;
    step();
    n_checks++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_restart: got fs=%b, expected fs=1", frame_start);
    end
    step();
    step();
    n_checks++;
    if ({digit_sel, digit_val} !== {2'd0, 4'h4}) begin
      n_fail++;
      $display("FAIL rmid_phase: got sel=%0d val=%h, expected sel=0 val=4", digit_sel, digit_val);
    end
    for (int i = 0; i < 29; i++) step();
    n_checks++;
    if ({digit_sel, digit_val, frame_start} !== {2'd3, 4'h1, 1'b0}) begin
      n_fail++;
      $display("FAIL wrapdrop_pre: got sel=%0d val=%h fs=%b, expected sel=3 val=1 fs=0",
               digit_sel, digit_val, frame_start);
    end
    enable    = 1'b0;
    digits_in = 16'h9999;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if ({digit_sel, digit_val, frame_start} !== {2'd0, 4'hF, 1'b0}) begin
        n_fail++;
        $display("FAIL wrapdrop[%0d]: got sel=%0d val=%h fs=%b, expected sel=0 val=f fs=0",
                 i, digit_sel, digit_val, frame_start);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_snapshot();
    test_blink_lz_illegal();
    test_enable_drop();
    test_reset_mid_and_wrap_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
